// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Defines the fetch FSM states, the datapath widths and the queue entry layout.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  // Encoding of the assembler NOP, shown on out_instr whenever the queue is empty.
  localparam logic [INSTR_W-1:0] ASM_NOP = 16'h0000;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with a flush that wins over push/pop.
// Push while full is honoured only when a pop happens in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rd_data   = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only observed after a push wrote it,
  // and the count/pointers (which are reset) decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, drives instruction_memory and queues words toward decode.
// Redirects from execute flush the queue and reload the PC, taking priority over all else.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               DEPTH    = 2,
  parameter logic [PC_W-1:0]  RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [PC_W-1:0] r_fetch_pc;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: combinational logic uses blocking '=' and assigns a default first,
  // so every path drives the signal and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_IDLE: if (run)  w_state_next = FETCH_RUN;
      FETCH_RUN:  if (!run) w_state_next = FETCH_IDLE;
      default:    w_state_next = FETCH_IDLE;
    endcase
  end

  // A pop during a redirect cycle still happens here but is wiped by the flush.
  assign w_pop  = out_valid & out_ready;
  assign w_push = (r_state == FETCH_RUN) & ~redirect_valid & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_fetch_pc <= RESET_PC;
    else if (redirect_valid) r_fetch_pc <= redirect_pc;
    else if (w_push)         r_fetch_pc <= r_fetch_pc + 16'd1;
  end

  assign imem_addr        = r_fetch_pc;
  assign w_wr_entry.pc    = r_fetch_pc;
  assign w_wr_entry.instr = imem_instr;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (redirect_valid),
    .wr_data (w_wr_entry),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Outputs depend only on queue state, never on redirect_valid or out_ready.
  assign out_valid = ~w_empty;
  assign out_instr = out_valid ? w_head.instr : ASM_NOP;
  assign out_pc    = out_valid ? w_head.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, PC wrap, drain, idle redirect, reset.
// A combinational memory model returns a known word for every address.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_unit #(
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic v, input logic [15:0] pc);
    check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
    check({tag, ".pc"},    out_pc,    v ? pc : 16'h0000);
    check({tag, ".instr"}, out_instr, v ? mem_word(pc) : NOP);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    run            = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;

    #12;
    head("reset", 1'b0, 16'h0);
    check("reset.addr", imem_addr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    head("idle", 1'b0, 16'h0);
    check("idle.addr", imem_addr, 16'h0000);

    // Streaming: state enters RUN on the first edge, first push on the next.
    run = 1'b1; out_ready = 1'b1;
    step();
    head("t1.enter_run", 1'b0, 16'h0);
    check("t1.enter_run.addr", imem_addr, 16'h0000);
    step();
    head("t1.first", 1'b1, 16'h0000);
    check("t1.first.addr", imem_addr, 16'h0001);
    for (int i = 1; i <= 5; i++) begin
      step();
      head("t1.stream", 1'b1, i[15:0]);
    end
    check("t1.addr", imem_addr, 16'h0006);

    // Redirect while out_pc=5: one empty cycle, then the target stream.
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect_valid = 1'b0;
    head("t3.bubble", 1'b0, 16'h0);
    check("t3.bubble.addr", imem_addr, 16'h0010);
    step();
    head("t3.tgt0", 1'b1, 16'h0010);
    step();
    head("t3.tgt1", 1'b1, 16'h0011);
    check("t3.addr", imem_addr, 16'h0012);

    // Stall: queue fills to DEPTH and the PC holds, then drains with no bubble.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      head("t2.stall", 1'b1, 16'h0011);
      check("t2.stall.addr", imem_addr, 16'h0013);
    end
    out_ready = 1'b1;
    step();
    head("t2.resume0", 1'b1, 16'h0012);
    step();
    head("t2.resume1", 1'b1, 16'h0013);
    step();
    head("t2.resume2", 1'b1, 16'h0014);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    head("t4.bubble", 1'b0, 16'h0);
    check("t4.bubble.addr", imem_addr, 16'hFFFF);
    step();
    head("t4.top", 1'b1, 16'hFFFF);
    check("t4.top.addr", imem_addr, 16'h0000);
    step();
    head("t4.wrap", 1'b1, 16'h0000);
    check("t4.wrap.addr", imem_addr, 16'h0001);

    // run falls with two entries queued; they drain and fetch holds at 9.
    redirect_valid = 1'b1; redirect_pc = 16'h0007; out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    check("t5.load.addr", imem_addr, 16'h0007);
    step();
    step();
    head("t5.full", 1'b1, 16'h0007);
    check("t5.full.addr", imem_addr, 16'h0009);
    run = 1'b0;
    step();
    head("t5.stopped", 1'b1, 16'h0007);
    check("t5.stopped.addr", imem_addr, 16'h0009);
    out_ready = 1'b1;
    step();
    head("t5.drain", 1'b1, 16'h0008);
    step();
    head("t5.empty", 1'b0, 16'h0);
    check("t5.empty.addr", imem_addr, 16'h0009);
    step();
    head("t5.hold", 1'b0, 16'h0);
    check("t5.hold.addr", imem_addr, 16'h0009);
    run = 1'b1;
    step();
    head("t5.rerun", 1'b0, 16'h0);
    step();
    head("t5.resume", 1'b1, 16'h0009);
    check("t5.resume.addr", imem_addr, 16'h000A);

    // Redirect while idle: PC loads, nothing is fetched until run returns.
    run = 1'b0;
    step();
    head("idle_redir.last", 1'b1, 16'h000A);
    step();
    head("idle_redir.drained", 1'b0, 16'h0);
    redirect_valid = 1'b1; redirect_pc = 16'h0030;
    step();
    redirect_valid = 1'b0;
    check("idle_redir.addr", imem_addr, 16'h0030);
    step();
    step();
    head("idle_redir.quiet", 1'b0, 16'h0);
    check("idle_redir.quiet.addr", imem_addr, 16'h0030);

    // Asynchronous reset with a full queue.
    out_ready = 1'b0; run = 1'b1;
    step();
    step();
    step();
    head("t6.full", 1'b1, 16'h0030);
    check("t6.full.addr", imem_addr, 16'h0032);
    #3 rst_n = 1'b0;
    #1;
    head("t6.async", 1'b0, 16'h0);
    check("t6.async.addr", imem_addr, 16'h0000);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    head("t6.restart_run", 1'b0, 16'h0);
    check("t6.restart_run.addr", imem_addr, 16'h0000);
    step();
    head("t6.restart0", 1'b1, 16'h0000);
    step();
    head("t6.restart1", 1'b1, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
